seq_alu: RTL and testbench

Next-generation execute unit for the RISC-V core. It keeps all base integer ALU operations and adds the RV32M multiply/divide/remainder set through an iterative radix-2 datapath. The unit is pipelined behind a valid/ready handshake on both sides, so the issue stage can stall on it. Result and ONZC flags are registered and held until consumed.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/mdu_iter.sv | 95 +++++++++
 rtl/seq_alu.sv | 177 +++++++++++++++++
 tb/tb_seq_alu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, flag bit positions and FSM states.
package alu_pkg;

   typedef enum logic [4:0] {
      OpAdd    = 5'h00,
      OpSub    = 5'h01,
      OpAnd    = 5'h02,
      OpOr     = 5'h03,
      OpXor    = 5'h04,
      OpSlt    = 5'h05,
      OpSll    = 5'h06,
      OpSltu   = 5'h07,
      OpSrl    = 5'h08,
      OpSra    = 5'h09,
      OpSubu   = 5'h0A,
      OpMul    = 5'h10,
      OpMulh   = 5'h11,
      OpMulhsu = 5'h12,
      OpMulhu  = 5'h13,
      OpDiv    = 5'h14,
      OpDivu   = 5'h15,
      OpRem    = 5'h16,
      OpRemu   = 5'h17
   } alu_op_e;

   localparam int unsigned FLAG_O = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide: shift-add multiplier and restoring divider sharing one
// double-width accumulator; operands are iterated as magnitudes and the sign fixed at the end.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int unsigned  REG_BITS = 32,
   localparam int unsigned SH_BITS  = $clog2(REG_BITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                start,
   input  logic [4:0]          op,
   input  logic [REG_BITS-1:0] A,
   input  logic [REG_BITS-1:0] B,
   output logic                busy,
   output logic                done,
   output logic [REG_BITS-1:0] result
);
   localparam int unsigned W = REG_BITS;

   logic [4:0]         op_q;
   logic               neg_q, busy_q;
   logic [W-1:0]       opnd_q;
   logic [2*W-1:0]     acc_q, acc_nxt, prod;
   logic [SH_BITS-1:0] cnt_q;

   logic               a_neg, b_neg, ge;
   logic [W-1:0]       a_mag, b_mag, rem_sub, quo_fix, rem_fix;
   logic [W:0]         sum, rem_sh;

   always_comb begin
      a_neg = (op inside {OpMulh, OpMulhsu, OpDiv, OpRem}) && A[W-1];
      b_neg = (op inside {OpMulh, OpDiv, OpRem}) && B[W-1];
      a_mag = a_neg ? -A : A;
      b_mag = b_neg ? -B : B;
   end

   // Multiply: {acc_hi, multiplier} shifts right; divide: {remainder, quotient} shifts left.
   always_comb begin
      sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
      rem_sh  = acc_q[2*W-1:W-1];
      ge      = rem_sh >= {1'b0, opnd_q};
      rem_sub = W'(rem_sh - {1'b0, opnd_q});
      if (op_q[2]) begin
         acc_nxt = ge ? {rem_sub, acc_q[W-2:0], 1'b1} : {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
      end else begin
         acc_nxt = acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
      end
      prod    = neg_q ? -acc_nxt : acc_nxt;
      quo_fix = neg_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
      rem_fix = neg_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
      case (op_q)
         OpMul:         result = prod[W-1:0];
         OpDiv, OpDivu: result = quo_fix;
         OpRem, OpRemu: result = rem_fix;
         default:       result = prod[2*W-1:W];
      endcase
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == SH_BITS'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
      end else if (flush) begin
         busy_q <= 1'b0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         op_q   <= op;
         neg_q  <= (op == OpRem) ? a_neg : (a_neg ^ b_neg);
         if (op[2]) begin
            acc_q  <= {{W{1'b0}}, a_mag};
            opnd_q <= b_mag;
         end else begin
            acc_q  <= {{W{1'b0}}, b_mag};
            opnd_q <= a_mag;
         end
      end else if (busy_q) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + SH_BITS'(1);
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Execute unit: valid/ready handshake FSM, single-cycle base ops and divide early-outs,
// with RV32M multiply/divide delegated to mdu_iter; result and flags held until consumed.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned  REG_BITS = 32,
   localparam int unsigned SH_BITS  = $clog2(REG_BITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [4:0]          ctrl,
   input  logic [REG_BITS-1:0] A,
   input  logic [REG_BITS-1:0] B,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [REG_BITS-1:0] C,
   output logic [3:0]          ONZC
);
   localparam int unsigned W = REG_BITS;
   localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

   state_e             state_q, state_d;
   logic [W-1:0]       c_q, c_d, alu_res, mdu_res;
   logic [3:0]         onzc_q, onzc_d, alu_flags;
   logic               accept, m_op, early, mdu_start, mdu_busy, mdu_done;
   logic               fo, fn, fc;
   logic [W:0]         add_w, sub_w, sll_w, srl_w, sra_w;
   logic [SH_BITS-1:0] sh;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign m_op      = (ctrl[4:3] == 2'b10);
   assign out_valid = (state_q == DONE);
   assign C         = c_q;
   assign ONZC      = onzc_q;

   always_comb begin
      sh    = B[SH_BITS-1:0];
      add_w = {1'b0, A} + {1'b0, B};
      sub_w = {1'b0, A} - {1'b0, B};
      sll_w = {1'b0, A} << sh;
      srl_w = {A, 1'b0} >> sh;
      sra_w = $signed({A, 1'b0}) >>> sh;
      alu_res = '0;
      early   = 1'b0;
      fo      = 1'b0;
      fn      = 1'b0;
      fc      = 1'b0;
      case (ctrl)
         OpAdd: begin
            alu_res = add_w[W-1:0];
            fc      = add_w[W];
            fn      = alu_res[W-1];
            fo      = (A[W-1] == B[W-1]) && (alu_res[W-1] != A[W-1]);
         end
         OpSub: begin
            alu_res = sub_w[W-1:0];
            fc      = sub_w[W];
            fn      = alu_res[W-1];
            fo      = (A[W-1] != B[W-1]) && (alu_res[W-1] != A[W-1]);
         end
         OpAnd:  alu_res = A & B;
         OpOr:   alu_res = A | B;
         OpXor:  alu_res = A ^ B;
         OpSlt:  alu_res = {{(W-1){1'b0}}, $signed(A) < $signed(B)};
         OpSltu: alu_res = {{(W-1){1'b0}}, A < B};
         OpSll: begin
            alu_res = sll_w[W-1:0];
            fc      = sll_w[W];
            fn      = alu_res[W-1];
         end
         OpSrl: begin
            alu_res = srl_w[W:1];
            fc      = srl_w[0];
            fn      = alu_res[W-1];
         end
         OpSra: begin
            alu_res = sra_w[W:1];
            fc      = sra_w[0];
            fn      = alu_res[W-1];
         end
         OpSubu: begin
            alu_res = sub_w[W-1:0];
            fo      = sub_w[W];
         end
         // ctrl[1] selects remainder, ctrl[0] selects unsigned.
         OpDiv, OpDivu, OpRem, OpRemu: begin
            if (B == '0) begin
               early   = 1'b1;
               fo      = 1'b1;
               alu_res = ctrl[1] ? A : '1;
            end else if (!ctrl[0] && (A == MinNeg) && (B == '1)) begin
               early   = 1'b1;
               fo      = 1'b1;
               alu_res = ctrl[1] ? '0 : A;
            end
            fn = alu_res[W-1];
         end
         default: ;
      endcase
      alu_flags         = '0;
      alu_flags[FLAG_O] = fo;
      alu_flags[FLAG_N] = fn;
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_C] = fc;
   end

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      onzc_d    = onzc_q;
      mdu_start = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  if (m_op && !early) begin
                     state_d   = BUSY;
                     mdu_start = 1'b1;
                  end else begin
                     state_d = DONE;
                     c_d     = alu_res;
                     onzc_d  = alu_flags;
                  end
               end else if (state_q == DONE && out_ready) begin
                  state_d = IDLE;
               end
            end
            BUSY: begin
               if (mdu_done) begin
                  state_d        = DONE;
                  c_d            = mdu_res;
                  onzc_d         = '0;
                  onzc_d[FLAG_N] = mdu_res[W-1];
                  onzc_d[FLAG_Z] = (mdu_res == '0);
               end else if (!mdu_busy) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         c_q     <= '0;
         onzc_q  <= 4'b0010;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         onzc_q  <= onzc_d;
      end
   end

   mdu_iter #(
      .REG_BITS(REG_BITS)
   ) u_mdu (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .start (mdu_start),
      .op    (ctrl),
      .A     (A),
      .B     (B),
      .busy  (mdu_busy),
      .done  (mdu_done),
      .result(mdu_res)
   );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table with latency/result/flag checks plus handshake,
// flush and asynchronous-reset sequences.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [4:0]   ctrl = '0;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] C;
   logic [3:0]   ONZC;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   seq_alu #(
      .REG_BITS(W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .ctrl     (ctrl),
      .A        (A),
      .B        (B),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .C        (C),
      .ONZC     (ONZC)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [3:0] f, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.c = c; v.f = f; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Offer one op, return edges from the accepting edge (counted as 1) until out_valid.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int edges);
      @(negedge clk);
      ctrl = op; A = a; B = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 1;
      while (!out_valid && edges < 60) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int seen;

      #12;
      check("reset out_valid", out_valid, 0);
      check("reset C", C, 0);
      check("reset ONZC", ONZC, 4'b0010);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset in_ready", in_ready, 1);

      add_vec(OpAdd,    32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1100, 1);
      add_vec(OpSub,    32'h5,        32'h5,        32'h0,        4'b0010, 1);
      add_vec(OpSub,    32'h0,        32'h1,        32'hFFFFFFFF, 4'b0101, 1);
      add_vec(OpAdd,    32'hFFFFFFFF, 32'h1,        32'h0,        4'b0011, 1);
      add_vec(OpAnd,    32'hF0,       32'h3C,       32'h30,       4'b0000, 1);
      add_vec(OpOr,     32'hF0,       32'h0F,       32'hFF,       4'b0000, 1);
      add_vec(OpXor,    32'hFF,       32'hFF,       32'h0,        4'b0010, 1);
      add_vec(OpSlt,    32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1);
      add_vec(OpSltu,   32'hFFFFFFFF, 32'h1,        32'h0,        4'b0010, 1);
      add_vec(OpSll,    32'h80000001, 32'h1,        32'h2,        4'b0001, 1);
      add_vec(OpSll,    32'h1,        32'h0,        32'h1,        4'b0000, 1);
      add_vec(OpSrl,    32'h3,        32'h1,        32'h1,        4'b0001, 1);
      add_vec(OpSrl,    32'h4,        32'h21,       32'h2,        4'b0000, 1);
      add_vec(OpSra,    32'h80000008, 32'h4,        32'hF8000000, 4'b0101, 1);
      add_vec(OpSubu,   32'h1,        32'h2,        32'hFFFFFFFF, 4'b1000, 1);
      add_vec(5'h0B,    32'h12,       32'h34,       32'h0,        4'b0010, 1);
      add_vec(OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 33);
      add_vec(OpMulh,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 4'b0100, 33);
      add_vec(OpMul,    32'h3,        32'hFFFFFFFE, 32'hFFFFFFFA, 4'b0100, 33);
      add_vec(OpMulhsu, 32'h2,        32'hFFFFFFFF, 32'h1,        4'b0000, 33);
      add_vec(OpDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1100, 1);
      add_vec(OpRemu,   32'h7,        32'h0,        32'h7,        4'b1000, 1);
      add_vec(OpDivu,   32'h5,        32'h0,        32'hFFFFFFFF, 4'b1100, 1);
      add_vec(OpRem,    32'h80000000, 32'hFFFFFFFF, 32'h0,        4'b1010, 1);
      add_vec(OpDiv,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 4'b0100, 33);
      add_vec(OpRem,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 4'b0100, 33);
      add_vec(OpRemu,   32'd100,      32'd7,        32'd2,        4'b0000, 33);
      add_vec(OpDiv,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0100, 33);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d C", i), C, vecs[i].c);
         check($sformatf("vec%0d ONZC", i), ONZC, vecs[i].f);
      end

      // Back-pressure: result must hold while the consumer stalls.
      @(posedge clk); #1;
      out_ready = 1'b0;
      run_op(OpDivu, 32'd100, 32'd7, lat);
      check("divu latency", lat, 33);
      check("divu C", C, 32'd14);
      @(negedge clk);
      ctrl = OpAdd; A = 32'd2; B = 32'd3; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d C", k), C, 32'd14);
         check($sformatf("stall%0d in_ready", k), in_ready, 0);
         check($sformatf("stall%0d out_valid", k), out_valid, 1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("release in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("no-bubble out_valid", out_valid, 1);
      check("no-bubble C", C, 32'd5);
      check("no-bubble ONZC", ONZC, 4'b0000);

      // Flush in the middle of a multiply.
      @(negedge clk);
      ctrl = OpMul; A = 32'd3; B = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mul busy out_valid", out_valid, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush out_valid", out_valid, 0);
      check("flush in_ready", in_ready, 1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("flush discards mul", seen, 0);
      run_op(OpAnd, 32'hF0, 32'h3C, lat);
      check("and latency", lat, 1);
      check("and C", C, 32'h30);
      check("and ONZC", ONZC, 4'b0000);

      // Accept offered in the same cycle as flush is dropped.
      @(negedge clk);
      ctrl = OpAdd; A = 32'd1; B = 32'd1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush+accept out_valid", out_valid, 0);
      @(posedge clk); #1;
      check("flush+accept later out_valid", out_valid, 0);

      // Asynchronous reset between edges while busy.
      @(negedge clk);
      ctrl = OpMulhu; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", out_valid, 0);
      check("async rst C", C, 0);
      check("async rst ONZC", ONZC, 4'b0010);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post rst in_ready", in_ready, 1);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("rst discards mul", seen, 0);
      run_op(OpAdd, 32'd1, 32'd1, lat);
      check("add after rst C", C, 32'd2);
      run_op(5'h1F, 32'hDEAD, 32'hBEEF, lat);
      check("undef latency", lat, 1);
      check("undef C", C, 0);
      check("undef ONZC", ONZC, 4'b0010);

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
